wb_write_buffer: RTL and testbench
==================================

Name: wb_write_buffer

Overview:
- Line-granular write-back buffer between the set-associative cache's memory port and the line-based main memory.
- Absorbs dirty-line swap-outs so a cache miss can start its swap-in without waiting for the writeback to reach memory.
- Forwards reads that hit a buffered line, and lets read misses bypass queued writes.
- Drains queued lines to memory in FIFO order when memory is otherwise idle.

Parameters:
- LINE_ADDR_LEN, 3: words per line = 2^LINE_ADDR_LEN; line width LW = 32*2^LINE_ADDR_LEN.
- ADDR_LEN, 9: line address width (tag+set).
- DEPTH, 4: buffer entries, power of two, >=2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- up_addr  in  ADDR_LEN  line address from cache.
- up_rd_req  in  1  cache line read (swap-in), level, held until up_gnt.
- up_wr_req  in  1  cache line write (swap-out), level, held until up_gnt.
- up_wr_line  in  LW  line to write; word k at bits [32k+31:32k].
- up_rd_line  out  LW  read result, registered, stable until next read response.
- up_gnt  out  1  one-cycle completion pulse to cache.
- mem_addr  out  ADDR_LEN  line address to main memory.
- mem_rd_req  out  1  memory read, registered level.
- mem_wr_req  out  1  memory write, registered level.
- mem_wr_line  out  LW  line to memory.
- mem_rd_line  in  LW  memory read data, valid in mem_gnt cycle.
- mem_gnt  in  1  one-cycle memory completion pulse.

Behaviour:
- Reset: all outputs 0; count, head and tail pointers 0; all entry-valid flags 0; FSM to IDLE. Reset at any point, including mid-transaction, discards buffered data and drops mem_*_req on the next cycle.
- Storage: DEPTH entries of {addr, line}; circular head/tail; count 0..DEPTH; full = (count==DEPTH); empty = (count==0).
- Upstream rule: a request is sampled only when up_gnt==0. The cycle in which up_gnt is high ignores up_*_req, because the cache still holds the request then. up_rd_req and up_wr_req are never both high; if they are, the write wins.
- Write accept: sampled with !full -> enqueue at tail on that edge; up_gnt=1 the next cycle (latency 1). If full, no gnt; retry every cycle until a drain frees a slot.
- Enqueue and drain-complete in the same cycle: count unchanged; pointers both advance.
- Read hit: up_addr matches any valid entry -> up_rd_line <= youngest matching entry line; up_gnt next cycle (latency 1); no memory access.
- Read miss: goes to memory and bypasses queued writes, since they hold different addresses.
- FSM states and transitions:
  - IDLE: read miss pending -> RD, mem_rd_req=1, mem_addr=up_addr. Otherwise !empty -> WR, mem_wr_req=1, mem_addr/mem_wr_line = head entry. Read miss has priority over drain.
  - RD: hold request until mem_gnt. On mem_gnt: capture mem_rd_line into up_rd_line, drop mem_rd_req, go to RESP.
  - RESP: up_gnt=1 for one cycle -> IDLE.
  - WR: hold until mem_gnt. On mem_gnt: dequeue head, count-1, drop mem_wr_req -> IDLE.
  - While in WR, an upstream read miss waits for the drain to finish.
- Concurrency: upstream writes are accepted in any FSM state. Read hits are served only in IDLE or WR. Only one up_gnt source is active per cycle.
- Head entry in flight (WR) stays matchable for read forwarding until its dequeue.
- mem_wr_line, mem_addr stay stable while a request is high; they are 0 when idle.

Optional Feature:
- Macro WB_COALESCE_EN.
- Defined: a write whose addr matches a valid entry that is not the head currently in WR overwrites that entry's line in place. No new slot is used, count is unchanged, and up_gnt follows with latency 1 even when full.
- A match on the in-flight head allocates a new entry as normal.
- Undefined: every accepted write allocates a new entry; duplicates drain in order.

Test Plan:
- Write addr 0x012 line L1 (empty buffer) -> up_gnt cycle+1. Then read 0x012 -> up_rd_line==L1, gnt latency 1, mem_rd_req never asserted.
- With memory gnt delayed 50 cycles, write 0x001..0x004 -> four gnts. Write 0x005 -> no gnt until first mem_gnt, then gnt next cycle. Memory sees writes in order 0x001,0x002,0x003,0x004,0x005.
- Buffer holds 0x020, memory idle. Read miss 0x030 -> mem_rd_req precedes any mem_wr_req; up_rd_line==mem data; gnt in RESP. Then 0x020 drains.
- Read 0x020 while 0x020 is head in WR -> forwarded from buffer, no memory read.
- rst for 1 cycle mid-WR with 3 entries -> next cycle mem_wr_req=0, up_gnt=0, count=0. A following read of a previously buffered addr goes to memory.
- WB_COALESCE_EN: writes 0x040 L1, 0x041 L2, 0x040 L3 -> count==2. Memory receives 0x040 L3 then 0x041 L2. Without the macro: count==3, three memory writes in order.

Source files
------------

// File: rtl/wb_write_buffer_if.sv
// Bus bundle for the write-back buffer: cache-side (up_*) and memory-side (mem_*) signals.
// slave is the buffer's view, master is the view of whatever drives the cache/memory side.
interface wb_write_buffer_if #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9
);
  localparam int unsigned LW = 32 << LINE_ADDR_LEN;

  logic [ADDR_LEN-1:0] up_addr;
  logic                up_rd_req;
  logic                up_wr_req;
  logic [LW-1:0]       up_wr_line;
  logic [LW-1:0]       up_rd_line;
  logic                up_gnt;

  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_rd_req;
  logic                mem_wr_req;
  logic [LW-1:0]       mem_wr_line;
  logic [LW-1:0]       mem_rd_line;
  logic                mem_gnt;

  modport slave (
    input  up_addr, up_rd_req, up_wr_req, up_wr_line, mem_rd_line, mem_gnt,
    output up_rd_line, up_gnt, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line
  );

  modport master (
    output up_addr, up_rd_req, up_wr_req, up_wr_line, mem_rd_line, mem_gnt,
    input  up_rd_line, up_gnt, mem_addr, mem_rd_req, mem_wr_req, mem_wr_line
  );
endinterface

// File: rtl/wb_write_buffer.sv
// Line-granular write-back buffer between the cache memory port and main memory.
// Swap-outs are queued, read hits are forwarded from the queue, read misses bypass queued
// writes, and queued lines drain to memory in FIFO order when memory is idle.
// Optional macro WB_COALESCE_EN: a write to an already-queued line (other than the line
// currently being drained) overwrites that entry in place instead of allocating a slot.
module wb_write_buffer #(
  parameter int unsigned LINE_ADDR_LEN = 3,
  parameter int unsigned ADDR_LEN      = 9,
  parameter int unsigned DEPTH         = 4
) (
  input logic              clk,
  input logic              rst,
  wb_write_buffer_if.slave bus
);
  localparam int unsigned LW   = 32 << LINE_ADDR_LEN;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRd, StResp, StWr} state_e;

  state_e state_q, state_d;

  logic [ADDR_LEN-1:0] addr_q [DEPTH];
  logic [LW-1:0]       line_q [DEPTH];
  logic [DEPTH-1:0]    vld_q;
  logic [PtrW-1:0]     head_q, tail_q;
  logic [CntW-1:0]     count_q;

  logic                up_gnt_q, up_gnt_d;
  logic [LW-1:0]       up_rd_line_q, up_rd_line_d;
  logic                mem_rd_req_q, mem_rd_req_d;
  logic                mem_wr_req_q, mem_wr_req_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]       mem_wr_line_q, mem_wr_line_d;

  logic            full, empty;
  logic            wr_sample, rd_sample;
  logic            rd_done, deq, enq, wr_accept, coalesce;
  logic            rd_miss_go, rd_hit_serve;
  logic            rd_hit;
  logic [LW-1:0]   rd_hit_line;
  logic [PtrW-1:0] rd_idx;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);

  // A request is only looked at while no grant is outstanding; write wins over read.
  assign wr_sample = bus.up_wr_req && !up_gnt_q;
  assign rd_sample = bus.up_rd_req && !bus.up_wr_req && !up_gnt_q;

  assign rd_done      = (state_q == StRd) && bus.mem_gnt;
  assign deq          = (state_q == StWr) && bus.mem_gnt;
  assign rd_miss_go   = (state_q == StIdle) && rd_sample && !rd_hit;
  assign rd_hit_serve = rd_sample && rd_hit && ((state_q == StIdle) || (state_q == StWr));

  // A slot freed by a drain completing this cycle can be reused on the same edge.
  // A read completing in RD owns the grant slot this cycle, so a write retries.
  assign wr_accept = wr_sample && !rd_done && (coalesce || !full || deq);
  assign enq       = wr_accept && !coalesce;

  // Read lookup: scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_line = '0;
    rd_idx      = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rd_idx = head_q + PtrW'(i);
      if (vld_q[rd_idx] && (addr_q[rd_idx] == bus.up_addr)) begin
        rd_hit      = 1'b1;
        rd_hit_line = line_q[rd_idx];
      end
    end
  end

`ifdef WB_COALESCE_EN
  logic            launch_wr, head_locked, wr_match;
  logic [PtrW-1:0] wr_idx, wr_match_idx;

  // Head is locked once its line is (or is about to be) latched into mem_wr_line.
  assign launch_wr   = (state_q == StIdle) && !rd_miss_go && !empty;
  assign head_locked = (state_q == StWr) || launch_wr;

  // Write lookup: youngest matching entry that is not the locked head.
  always_comb begin
    wr_match     = 1'b0;
    wr_match_idx = '0;
    wr_idx       = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_idx = head_q + PtrW'(i);
      if (vld_q[wr_idx] && (addr_q[wr_idx] == bus.up_addr) && !(head_locked && (i == 0))) begin
        wr_match     = 1'b1;
        wr_match_idx = wr_idx;
      end
    end
  end

  assign coalesce = wr_sample && wr_match;
`else
  assign coalesce = 1'b0;
`endif

  // Next state and memory-side request registers.
  always_comb begin
    state_d       = state_q;
    mem_rd_req_d  = mem_rd_req_q;
    mem_wr_req_d  = mem_wr_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_line_d = mem_wr_line_q;
    unique case (state_q)
      StIdle: begin
        if (rd_miss_go) begin
          state_d       = StRd;
          mem_rd_req_d  = 1'b1;
          mem_addr_d    = bus.up_addr;
          mem_wr_line_d = '0;
        end else if (!empty) begin
          state_d       = StWr;
          mem_wr_req_d  = 1'b1;
          mem_addr_d    = addr_q[head_q];
          mem_wr_line_d = line_q[head_q];
        end
      end
      StRd: begin
        if (bus.mem_gnt) begin
          state_d      = StResp;
          mem_rd_req_d = 1'b0;
          mem_addr_d   = '0;
        end
      end
      StResp: state_d = StIdle;
      StWr: begin
        if (bus.mem_gnt) begin
          state_d       = StIdle;
          mem_wr_req_d  = 1'b0;
          mem_addr_d    = '0;
          mem_wr_line_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Upstream grant and read data; the grant of a memory read lands in RESP.
  always_comb begin
    up_gnt_d     = wr_accept || rd_hit_serve || rd_done;
    up_rd_line_d = up_rd_line_q;
    if (rd_done) begin
      up_rd_line_d = bus.mem_rd_line;
    end else if (rd_hit_serve) begin
      up_rd_line_d = rd_hit_line;
    end
  end

  // Control state, queue bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      vld_q         <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      up_gnt_q      <= 1'b0;
      up_rd_line_q  <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_line_q <= '0;
    end else begin
      state_q       <= state_d;
      up_gnt_q      <= up_gnt_d;
      up_rd_line_q  <= up_rd_line_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_wr_req_q  <= mem_wr_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_line_q <= mem_wr_line_d;
      // Clear before set: when full, enqueue reuses the slot being dequeued.
      if (deq) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      if (enq) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + 1'b1;
      end
      if (enq && !deq) begin
        count_q <= count_q + 1'b1;
      end else if (deq && !enq) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Entry payload; validity is tracked in vld_q so no reset is needed here.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.up_addr;
      line_q[tail_q] <= bus.up_wr_line;
    end
`ifdef WB_COALESCE_EN
    else if (wr_accept && coalesce) begin
      line_q[wr_match_idx] <= bus.up_wr_line;
    end
`endif
  end

  assign bus.up_gnt      = up_gnt_q;
  assign bus.up_rd_line  = up_rd_line_q;
  assign bus.mem_rd_req  = mem_rd_req_q;
  assign bus.mem_wr_req  = mem_wr_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_line = mem_wr_line_q;
endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed self-checking bench for wb_write_buffer with a latency-programmable memory model.
module tb_wb_write_buffer;
  localparam int unsigned LAL   = 3;
  localparam int unsigned AL    = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 32 << LAL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_write_buffer_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) bus ();

  wb_write_buffer #(
    .LINE_ADDR_LEN(LAL),
    .ADDR_LEN     (AL),
    .DEPTH        (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state and event log ({is_write, addr} per completed request)
  int            mem_lat;
  int            busy;
  int            cyc;
  int            log_n;
  int            rd_cycles;
  logic [9:0]    log_ev   [64];
  int            log_cyc  [64];
  logic [LW-1:0] log_line [64];

  function automatic logic [LW-1:0] mk_line(input logic [AL-1:0] a, input logic [7:0] tag);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = {tag, 7'd0, 8'(k), a};
    return l;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  // Memory responder: grants mem_lat cycles after a request is first seen.
  initial begin
    bus.mem_gnt     = 1'b0;
    bus.mem_rd_line = '0;
    busy = 0; cyc = 0; log_n = 0; rd_cycles = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.mem_gnt) begin
        bus.mem_gnt = 1'b0;
        busy = 0;
      end else if (bus.mem_rd_req || bus.mem_wr_req) begin
        if (bus.mem_rd_req) rd_cycles++;
        if (busy >= mem_lat) begin
          bus.mem_gnt = 1'b1;
          busy = 0;
          if (log_n < 64) begin
            log_ev[log_n]   = {bus.mem_wr_req, bus.mem_addr};
            log_cyc[log_n]  = cyc;
            log_line[log_n] = bus.mem_wr_line;
            log_n++;
          end
          if (bus.mem_rd_req) bus.mem_rd_line = mk_line(bus.mem_addr, 8'hD0);
        end else begin
          busy++;
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic do_write(input logic [AL-1:0] a, input logic [LW-1:0] l, input int bound,
                          output int lat, output int gcyc);
    @(posedge clk); #1;
    bus.up_addr = a; bus.up_wr_line = l; bus.up_wr_req = 1'b1;
    lat = 0; gcyc = -1;
    while (lat < bound) begin
      @(posedge clk); #1;
      lat++;
      if (bus.up_gnt) break;
    end
    bus.up_wr_req = 1'b0;
    if (bus.up_gnt) gcyc = cyc;
    else lat = -1;
  endtask

  task automatic do_read(input logic [AL-1:0] a, input int bound, output int lat,
                         output logic [LW-1:0] line);
    @(posedge clk); #1;
    bus.up_addr = a; bus.up_rd_req = 1'b1;
    lat = 0;
    while (lat < bound) begin
      @(posedge clk); #1;
      lat++;
      if (bus.up_gnt) break;
    end
    bus.up_rd_req = 1'b0;
    line = bus.up_rd_line;
    if (!bus.up_gnt) lat = -1;
  endtask

  task automatic wait_idle(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (dut.count_q == '0 && !bus.mem_wr_req && !bus.mem_rd_req && !bus.mem_gnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gcyc, base, r0;
    logic ok;
    logic [LW-1:0] rl;
    logic [LW-1:0] exp_line [8];
    logic [9:0] exp_ev [8];

    rst = 1'b1;
    bus.up_addr = '0; bus.up_rd_req = 1'b0; bus.up_wr_req = 1'b0; bus.up_wr_line = '0;
    mem_lat = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_up_gnt", LW'(bus.up_gnt), '0);
    check("rst_up_rd_line", bus.up_rd_line, '0);
    check("rst_mem_rd_req", LW'(bus.mem_rd_req), '0);
    check("rst_mem_wr_req", LW'(bus.mem_wr_req), '0);
    check("rst_mem_addr", LW'(bus.mem_addr), '0);
    check("rst_mem_wr_line", bus.mem_wr_line, '0);
    check("rst_count", LW'(dut.count_q), '0);

    // T1: write then read-hit of the same line, no memory read
    mem_lat = 50; base = log_n; r0 = rd_cycles;
    do_write(9'h012, mk_line(9'h012, 8'h11), 8, lat, gcyc);
    check("t1_wr_lat", LW'(lat), LW'(1));
    do_read(9'h012, 8, lat, rl);
    check("t1_rd_lat", LW'(lat), LW'(1));
    check("t1_rd_line", rl, mk_line(9'h012, 8'h11));
    wait_idle(200, ok);
    check("t1_drained", LW'(ok), LW'(1));
    check("t1_no_mem_rd", LW'(rd_cycles - r0), '0);
    check("t1_mem_nwr", LW'(log_n - base), LW'(1));
    check("t1_mem_ev", LW'(log_ev[base]), LW'({1'b1, 9'h012}));
    check("t1_mem_line", log_line[base], mk_line(9'h012, 8'h11));

    // T2: fill to full behind a slow memory; fifth write waits for the first drain
    mem_lat = 50; base = log_n;
    for (int i = 1; i <= 4; i++) begin
      do_write(AL'(i), mk_line(AL'(i), 8'h20), 8, lat, gcyc);
      check("t2_wr_lat", LW'(lat), LW'(1));
    end
    do_write(9'h005, mk_line(9'h005, 8'h20), 200, lat, gcyc);
    check("t2_full_gnt_cyc", LW'(gcyc), LW'(log_cyc[base] + 1));
    check("t2_full_count", LW'(dut.count_q), LW'(4));
    wait_idle(600, ok);
    check("t2_drained", LW'(ok), LW'(1));
    check("t2_mem_nwr", LW'(log_n - base), LW'(5));
    for (int i = 0; i < 5; i++) begin
      check("t2_mem_ev", LW'(log_ev[base+i]), LW'({1'b1, 9'(i + 1)}));
      check("t2_mem_line", log_line[base+i], mk_line(9'(i + 1), 8'h20));
    end

    // T3: read miss waits for in-flight drain, then goes ahead of the queued 0x020
    mem_lat = 10; base = log_n;
    do_write(9'h021, mk_line(9'h021, 8'h33), 8, lat, gcyc);
    check("t3_wr_lat_a", LW'(lat), LW'(1));
    do_write(9'h020, mk_line(9'h020, 8'h33), 8, lat, gcyc);
    check("t3_wr_lat_b", LW'(lat), LW'(1));
    do_read(9'h030, 100, lat, rl);
    check("t3_rd_gnt", LW'(lat > 0), LW'(1));
    check("t3_rd_line", rl, mk_line(9'h030, 8'hD0));
    wait_idle(200, ok);
    check("t3_drained", LW'(ok), LW'(1));
    exp_ev[0] = {1'b1, 9'h021}; exp_ev[1] = {1'b0, 9'h030}; exp_ev[2] = {1'b1, 9'h020};
    check("t3_mem_n", LW'(log_n - base), LW'(3));
    for (int i = 0; i < 3; i++) check("t3_mem_order", LW'(log_ev[base+i]), LW'(exp_ev[i]));

    // T4: read of the head while it is being drained is forwarded
    mem_lat = 30; base = log_n; r0 = rd_cycles;
    do_write(9'h020, mk_line(9'h020, 8'h44), 8, lat, gcyc);
    do_read(9'h020, 8, lat, rl);
    check("t4_rd_lat", LW'(lat), LW'(1));
    check("t4_rd_line", rl, mk_line(9'h020, 8'h44));
    check("t4_head_in_wr", LW'(bus.mem_wr_req), LW'(1));
    check("t4_head_addr", LW'(bus.mem_addr), LW'(9'h020));
    wait_idle(200, ok);
    check("t4_no_mem_rd", LW'(rd_cycles - r0), '0);

    // T5: reset in the middle of a drain with three entries queued
    mem_lat = 40;
    do_write(9'h050, mk_line(9'h050, 8'h55), 8, lat, gcyc);
    do_write(9'h051, mk_line(9'h051, 8'h55), 8, lat, gcyc);
    do_write(9'h052, mk_line(9'h052, 8'h55), 8, lat, gcyc);
    check("t5_count3", LW'(dut.count_q), LW'(3));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_mem_wr_req", LW'(bus.mem_wr_req), '0);
    check("t5_up_gnt", LW'(bus.up_gnt), '0);
    check("t5_count", LW'(dut.count_q), '0);
    mem_lat = 2; base = log_n;
    do_read(9'h051, 50, lat, rl);
    check("t5_rd_line", rl, mk_line(9'h051, 8'hD0));
    check("t5_mem_n", LW'(log_n - base), LW'(1));
    check("t5_mem_ev", LW'(log_ev[base]), LW'({1'b0, 9'h051}));
    wait_idle(100, ok);

    // T6: duplicate address behind an in-flight drain of 0x03F
    mem_lat = 40; base = log_n;
    do_write(9'h03F, mk_line(9'h03F, 8'h66), 8, lat, gcyc);
    do_write(9'h040, mk_line(9'h040, 8'hA1), 8, lat, gcyc);
    do_write(9'h041, mk_line(9'h041, 8'hA2), 8, lat, gcyc);
    do_write(9'h040, mk_line(9'h040, 8'hA3), 8, lat, gcyc);
    check("t6_dup_wr_lat", LW'(lat), LW'(1));
    exp_ev[0] = {1'b1, 9'h03F}; exp_line[0] = mk_line(9'h03F, 8'h66);
`ifdef WB_COALESCE_EN
    check("t6_count", LW'(dut.count_q), LW'(3));
    exp_ev[1] = {1'b1, 9'h040}; exp_line[1] = mk_line(9'h040, 8'hA3);
    exp_ev[2] = {1'b1, 9'h041}; exp_line[2] = mk_line(9'h041, 8'hA2);
    wait_idle(600, ok);
    check("t6_mem_n", LW'(log_n - base), LW'(3));
    for (int i = 0; i < 3; i++) begin
      check("t6_mem_ev", LW'(log_ev[base+i]), LW'(exp_ev[i]));
      check("t6_mem_line", log_line[base+i], exp_line[i]);
    end
`else
    check("t6_count", LW'(dut.count_q), LW'(4));
    exp_ev[1] = {1'b1, 9'h040}; exp_line[1] = mk_line(9'h040, 8'hA1);
    exp_ev[2] = {1'b1, 9'h041}; exp_line[2] = mk_line(9'h041, 8'hA2);
    exp_ev[3] = {1'b1, 9'h040}; exp_line[3] = mk_line(9'h040, 8'hA3);
    wait_idle(600, ok);
    check("t6_mem_n", LW'(log_n - base), LW'(4));
    for (int i = 0; i < 4; i++) begin
      check("t6_mem_ev", LW'(log_ev[base+i]), LW'(exp_ev[i]));
      check("t6_mem_line", log_line[base+i], exp_line[i]);
    end
`endif
    check("t6_drained", LW'(ok), LW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
